cva5_flush_sequencer: RTL and testbench

CVA5_FLUSH_SEQUENCER -- requirements
Module: cva5_flush_sequencer

---
 rtl/cva5_flush_sequencer.sv | 199 +++++++++++++++++++
 tb/tb_cva5_flush_sequencer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cva5_flush_sequencer.sv
// Cache/branch-predictor flush sequencer: stalls the core, pulses the
// selected invalidate-all lines, waits for completion, then releases.
//
// Ports:
//   clk, rst_n          clock, async active-low reset
//   start, mask[2:0]    flush request; mask = {dcache, bp, icache}
//   busy, done          sequence active / one-cycle completion pulse
//   timeout             sticky wait-state timeout flag
//   dexie_stall         core stall request
//   *_set_invalidate_all   one-cycle invalidate pulses
//   *_invalidating_all     invalidation-in-progress status
module cva5_flush_sequencer #(
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] mask,
  output logic       busy,
  output logic       done,
  output logic       timeout,
  output logic       dexie_stall,
  output logic       icache_set_invalidate_all,
  output logic       bp_set_invalidate_all,
  output logic       dcache_set_invalidate_all,
  input  logic       icache_invalidating_all,
  input  logic       bp_invalidating_all,
  input  logic       dcache_invalidating_all
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_DC_ISSUE,
    S_DC_WAIT,
    S_IF_ISSUE,
    S_IF_WAIT,
    S_RELEASE
  } state_t;

  localparam logic [7:0]  SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TMO_LIMIT   = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] ARM_CYCLES  = 16'd2;

  state_t      r_state;
  logic [2:0]  r_cur_mask;
  logic [2:0]  r_pend_mask;
  logic        r_pend_valid;
  logic [15:0] r_cnt;
  logic [7:0]  r_settle;

  logic [15:0] w_cnt_inc;
  logic        w_tmo_hit;
  logic        w_armed;
  logic        w_if_sel;
  logic        w_if_busy;
  logic [2:0]  w_merge_mask;
  logic        w_merge_valid;

  assign w_cnt_inc = (r_cnt == 16'hFFFF) ? r_cnt : r_cnt + 16'd1;
  // Leave on the edge where the counter would reach the limit.
  assign w_tmo_hit = (w_cnt_inc >= TMO_LIMIT);
  // The core needs a couple of cycles to raise its status after a pulse.
  assign w_armed   = (r_cnt >= ARM_CYCLES);
  assign w_if_sel  = |r_cur_mask[1:0];
  assign w_if_busy = (r_cur_mask[0] & icache_invalidating_all)
                   | (r_cur_mask[1] & bp_invalidating_all);

  // A start landing in RELEASE must join the pending request.
  assign w_merge_mask  = r_pend_mask | (start ? mask : 3'b000);
  assign w_merge_valid = r_pend_valid | start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state                   <= S_IDLE;
      r_cur_mask                <= 3'b000;
      r_pend_mask               <= 3'b000;
      r_pend_valid              <= 1'b0;
      r_cnt                     <= 16'd0;
      r_settle                  <= 8'd0;
      busy                      <= 1'b0;
      done                      <= 1'b0;
      timeout                   <= 1'b0;
      dexie_stall               <= 1'b0;
      icache_set_invalidate_all <= 1'b0;
      bp_set_invalidate_all     <= 1'b0;
      dcache_set_invalidate_all <= 1'b0;
    end else begin
      done                      <= 1'b0;
      icache_set_invalidate_all <= 1'b0;
      bp_set_invalidate_all     <= 1'b0;
      dcache_set_invalidate_all <= 1'b0;

      if (r_state != S_IDLE && start) begin
        r_pend_mask  <= r_pend_mask | mask;
        r_pend_valid <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            timeout <= 1'b0;
            if (mask != 3'b000) begin
              r_cur_mask  <= mask;
              r_settle    <= SETTLE_LOAD;
              r_state     <= S_SETTLE;
              busy        <= 1'b1;
              dexie_stall <= 1'b1;
            end else begin
              done <= 1'b1;
            end
          end
        end

        S_SETTLE: begin
          if (r_settle != 8'd0) begin
            r_settle <= r_settle - 8'd1;
          end else if (r_cur_mask[2]) begin
            r_state <= S_DC_ISSUE;
          end else if (w_if_sel) begin
            r_state <= S_IF_ISSUE;
          end else begin
            r_state     <= S_RELEASE;
            dexie_stall <= 1'b0;
            done        <= 1'b1;
          end
        end

        S_DC_ISSUE: begin
          dcache_set_invalidate_all <= 1'b1;
          r_cnt   <= 16'd0;
          r_state <= S_DC_WAIT;
        end

        S_DC_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_tmo_hit) begin
            timeout     <= 1'b1;
            r_state     <= S_RELEASE;
            dexie_stall <= 1'b0;
            done        <= 1'b1;
          end else if (w_armed && !dcache_invalidating_all) begin
            if (w_if_sel) begin
              r_state <= S_IF_ISSUE;
            end else begin
              r_state     <= S_RELEASE;
              dexie_stall <= 1'b0;
              done        <= 1'b1;
            end
          end
        end

        S_IF_ISSUE: begin
          icache_set_invalidate_all <= r_cur_mask[0];
          bp_set_invalidate_all     <= r_cur_mask[1];
          r_cnt   <= 16'd0;
          r_state <= S_IF_WAIT;
        end

        S_IF_WAIT: begin
          r_cnt <= w_cnt_inc;
          if (w_tmo_hit) begin
            timeout     <= 1'b1;
            r_state     <= S_RELEASE;
            dexie_stall <= 1'b0;
            done        <= 1'b1;
          end else if (w_armed && !w_if_busy) begin
            r_state     <= S_RELEASE;
            dexie_stall <= 1'b0;
            done        <= 1'b1;
          end
        end

        S_RELEASE: begin
          r_pend_mask  <= 3'b000;
          r_pend_valid <= 1'b0;
          if (w_merge_valid) begin
            r_cur_mask  <= w_merge_mask;
            r_settle    <= SETTLE_LOAD;
            r_state     <= S_SETTLE;
            timeout     <= 1'b0;
            dexie_stall <= 1'b1;
          end else begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end

        default: begin
          r_state     <= S_IDLE;
          busy        <= 1'b0;
          dexie_stall <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cva5_flush_sequencer.sv
// Directed self-checking bench for cva5_flush_sequencer.
// Output vector order: {busy, done, timeout, stall, dc, bp, ic}.
module tb_cva5_flush_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;

  logic       start, start_b;
  logic [2:0] mask, mask_b;
  logic       ic_inv, bp_inv, dc_inv;
  logic       ic_inv_b, bp_inv_b, dc_inv_b;

  logic busy, done, tmo, stall, dc_p, bp_p, ic_p;
  logic busy_b, done_b, tmo_b, stall_b, dc_p_b, bp_p_b, ic_p_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  cva5_flush_sequencer #(
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(4096)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mask(mask),
    .busy(busy),
    .done(done),
    .timeout(tmo),
    .dexie_stall(stall),
    .icache_set_invalidate_all(ic_p),
    .bp_set_invalidate_all(bp_p),
    .dcache_set_invalidate_all(dc_p),
    .icache_invalidating_all(ic_inv),
    .bp_invalidating_all(bp_inv),
    .dcache_invalidating_all(dc_inv)
  );

  cva5_flush_sequencer #(
    .SETTLE_CYCLES(4),
    .TIMEOUT_CYCLES(16)
  ) dut_to (
    .clk(clk),
    .rst_n(rst_n),
    .start(start_b),
    .mask(mask_b),
    .busy(busy_b),
    .done(done_b),
    .timeout(tmo_b),
    .dexie_stall(stall_b),
    .icache_set_invalidate_all(ic_p_b),
    .bp_set_invalidate_all(bp_p_b),
    .dcache_set_invalidate_all(dc_p_b),
    .icache_invalidating_all(ic_inv_b),
    .bp_invalidating_all(bp_inv_b),
    .dcache_invalidating_all(dc_inv_b)
  );

  typedef struct {
    logic       s;
    logic [2:0] m;
    logic [2:0] st;
    logic [6:0] e;
  } vec_t;

  vec_t tbl[$];

  function automatic logic [6:0] outs_a();
    return {busy, done, tmo, stall, dc_p, bp_p, ic_p};
  endfunction

  function automatic logic [6:0] outs_b();
    return {busy_b, done_b, tmo_b, stall_b, dc_p_b, bp_p_b, ic_p_b};
  endfunction

  // Full flush, mask=111, zero-delay core, SETTLE_CYCLES=4.
  function automatic logic [6:0] full_exp(int c);
    logic [6:0] e;
    e[6] = (c >= 1 && c <= 13);
    e[5] = (c == 13);
    e[4] = 1'b0;
    e[3] = (c >= 1 && c <= 12);
    e[2] = (c == 6);
    e[1] = (c == 10);
    e[0] = (c == 10);
    return e;
  endfunction

  task automatic check(string nm, logic [6:0] act, logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %b want %b", nm, act, exp);
    end
  endtask

  task automatic add(int n, logic s, logic [2:0] m,
                     logic [2:0] st, logic [6:0] e);
    vec_t v;
    v.s  = s;
    v.m  = m;
    v.st = st;
    v.e  = e;
    for (int k = 0; k < n; k++) tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    start = 1'b0; mask = 3'b000;
    ic_inv = 1'b0; bp_inv = 1'b0; dc_inv = 1'b0;
    start_b = 1'b0; mask_b = 3'b000;
    ic_inv_b = 1'b0; bp_inv_b = 1'b0; dc_inv_b = 1'b0;

    // full flush, mask=111
    add(1, 1, 3'b111, 3'b000, 7'b0000000);
    add(5, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1001100);
    add(3, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1001011);
    add(2, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1100000);
    add(1, 0, 3'b000, 3'b000, 7'b0000000);
    // empty mask
    add(1, 1, 3'b000, 3'b000, 7'b0000000);
    add(1, 0, 3'b000, 3'b000, 7'b0100000);
    add(1, 0, 3'b000, 3'b000, 7'b0000000);
    // pending merge: 001 then 010 during SETTLE
    add(1, 1, 3'b001, 3'b000, 7'b0000000);
    add(1, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 1, 3'b010, 3'b000, 7'b1001000);
    add(3, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1001001);
    add(2, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1100000);
    add(5, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1001010);
    add(2, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1100000);
    add(1, 0, 3'b000, 3'b000, 7'b0000000);
    // IF_WAIT honours a selected busy icache
    add(1, 1, 3'b001, 3'b000, 7'b0000000);
    add(5, 0, 3'b000, 3'b001, 7'b1001000);
    add(1, 0, 3'b000, 3'b001, 7'b1001001);
    add(4, 0, 3'b000, 3'b001, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1100000);
    add(1, 0, 3'b000, 3'b000, 7'b0000000);
    // unselected busy bp is ignored
    add(1, 1, 3'b001, 3'b010, 7'b0000000);
    add(5, 0, 3'b000, 3'b010, 7'b1001000);
    add(1, 0, 3'b000, 3'b010, 7'b1001001);
    add(2, 0, 3'b000, 3'b010, 7'b1001000);
    add(1, 0, 3'b000, 3'b000, 7'b1100000);
    add(1, 0, 3'b000, 3'b000, 7'b0000000);

    repeat (2) @(posedge clk);
    #1;
    check("reset_a", outs_a(), 7'b0000000);
    check("reset_b", outs_b(), 7'b0000000);
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      check($sformatf("vec%0d", i), outs_a(), tbl[i].e);
      start  = tbl[i].s;
      mask   = tbl[i].m;
      dc_inv = tbl[i].st[2];
      bp_inv = tbl[i].st[1];
      ic_inv = tbl[i].st[0];
      tick();
    end
    start = 1'b0; mask = 3'b000;
    ic_inv = 1'b0; bp_inv = 1'b0; dc_inv = 1'b0;

    // slow dcache: busy for 20 cycles from cycle 7
    start = 1'b1; mask = 3'b100;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 32; c++) begin
      check($sformatf("slow_dc_c%0d", c), outs_a(),
            {c <= 28, c == 28, 1'b0, c <= 27, c == 6, 2'b00});
      dc_inv = (c >= 7 && c <= 26);
      tick();
    end

    // timeout on the 16-cycle instance
    start_b = 1'b1; mask_b = 3'b001; ic_inv_b = 1'b1;
    tick();
    start_b = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      check($sformatf("tmo_c%0d", c), outs_b(),
            {c <= 22, c == 22, c >= 22, c <= 21, 2'b00, c == 6});
      tick();
    end
    ic_inv_b = 1'b0;
    start_b = 1'b1; mask_b = 3'b000;
    tick();
    start_b = 1'b0;
    check("tmo_clear", outs_b(), 7'b0100000);
    tick();
    check("tmo_idle", outs_b(), 7'b0000000);

    // async reset during DC_WAIT
    start = 1'b1; mask = 3'b111;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("pre_rst_c%0d", c), outs_a(), full_exp(c));
      if (c < 7) tick();
    end
    dc_inv = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", outs_a(), 7'b0000000);
    tick();
    check("rst_no_done", outs_a(), 7'b0000000);
    dc_inv = 1'b0;
    rst_n = 1'b1;
    start = 1'b1; mask = 3'b111;
    tick();
    start = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      check($sformatf("restart_c%0d", c), outs_a(), full_exp(c));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
